// File: rtl/d24_fdm_dly_pkg.sv
// Shared constants for the D24/FDM cascaded load/hold delay line:
// legal parameter ranges and the per-stage select encoding.
package d24_fdm_dly_pkg;

  localparam int unsigned STAGES_MIN = 32'd1;
  localparam int unsigned STAGES_MAX = 32'd8;
  localparam int unsigned WIDTH_MIN  = 32'd1;
  localparam int unsigned WIDTH_MAX  = 32'd16;

  // A select bit of 1 recirculates the stage, 0 loads it from its source.
  localparam logic SEL_HOLD = 1'b1;
  localparam logic SEL_LOAD = 1'b0;

  typedef enum logic {
    STAGE_LOAD = SEL_LOAD,
    STAGE_HOLD = SEL_HOLD
  } stage_mode_e;

  // True when a parameter pair lies inside the supported range.
  function automatic logic params_legal(input int unsigned stages, input int unsigned width);
    params_legal = (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
                   (width  >= WIDTH_MIN)  && (width  <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/d24_fdm_stage.sv
// One delay-line stage: a D24 AND-OR-invert select cell feeding an FDM
// register; the stage output is the register's inverted output Qn.
module d24_fdm_stage
  import d24_fdm_dly_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] qn
);

  stage_mode_e      mode_s;
  logic [WIDTH-1:0] a2_s;
  logic [WIDTH-1:0] b2_s;
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] q_r;

  assign mode_s = stage_mode_e'(sel);
  assign a2_s   = {WIDTH{mode_s == STAGE_HOLD}};
  assign b2_s   = {WIDTH{mode_s == STAGE_LOAD}};

  // D24 cell: X = NOT((Qn AND hold) OR (src AND load)), bitwise.
  always_comb begin
    x_s = ~((qn & a2_s) | (src & b2_s));
  end

  // FDM register; stored ones make Qn read as zero out of reset.
  always_ff @(posedge ck) begin
    if (rst) begin
      q_r <= {WIDTH{1'b1}};
    end else begin
      q_r <= x_s;
    end
  end

  assign qn = ~q_r;

endmodule

// File: rtl/d24_fdm_dly.sv
// Cascade of STAGES D24/FDM stages forming a per-stage load/hold shift line.
// Every stage samples the pre-edge output of its predecessor, so loads shift.
module d24_fdm_dly
  import d24_fdm_dly_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned WIDTH  = 1
) (
  input  logic                    CK,
  input  logic                    RST,
  input  logic [WIDTH-1:0]        DIN,
  input  logic [STAGES-1:0]       SEL,
  output logic [STAGES*WIDTH-1:0] TAP,
  output logic [WIDTH-1:0]        DOUT
);

  logic [WIDTH-1:0] src_s [STAGES];

  generate
    if (!params_legal(STAGES, WIDTH)) begin : g_bad_params
      $error("d24_fdm_dly: STAGES or WIDTH outside supported range");
    end
  endgenerate

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign src_s[k] = DIN;
      end else begin : g_chain
        assign src_s[k] = TAP[(k-1)*WIDTH +: WIDTH];
      end

      d24_fdm_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .ck  (CK),
        .rst (RST),
        .sel (SEL[k]),
        .src (src_s[k]),
        .qn  (TAP[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

  assign DOUT = TAP[(STAGES-1)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_d24_fdm_dly.sv
// Bench for d24_fdm_dly: directed vector table on a 3x1 line, a directed
// 2x8 width sequence, then random traffic against an array-based model.
module tb_d24_fdm_dly;

  logic        ck;
  logic        rst_a, rst_b;
  logic [2:0]  sel_a;
  logic        din_a;
  logic [2:0]  tap_a;
  logic        dout_a;
  logic [1:0]  sel_b;
  logic [7:0]  din_b;
  logic [15:0] tap_b;
  logic [7:0]  dout_b;

  int vectors;
  int miscompares;

  // Behavioural model: one value per stage, shifted with array indexing.
  logic       m_a [3];
  logic [7:0] m_b [2];

  d24_fdm_dly #(.STAGES(3), .WIDTH(1)) u_dut_a (
    .CK(ck), .RST(rst_a), .DIN(din_a), .SEL(sel_a), .TAP(tap_a), .DOUT(dout_a)
  );

  d24_fdm_dly #(.STAGES(2), .WIDTH(8)) u_dut_b (
    .CK(ck), .RST(rst_b), .DIN(din_b), .SEL(sel_b), .TAP(tap_b), .DOUT(dout_b)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] sel;
    logic       din;
    logic [2:0] tap;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Advance both models by one edge using the stage rules directly.
  task automatic model_edge();
    logic       na [3];
    logic [7:0] nb [2];
    for (int k = 0; k < 3; k++) begin
      if (rst_a)          na[k] = 1'b0;
      else if (sel_a[k])  na[k] = m_a[k];
      else if (k == 0)    na[k] = din_a;
      else                na[k] = m_a[k-1];
    end
    for (int k = 0; k < 2; k++) begin
      if (rst_b)          nb[k] = 8'h00;
      else if (sel_b[k])  nb[k] = m_b[k];
      else if (k == 0)    nb[k] = din_b;
      else                nb[k] = m_b[k-1];
    end
    m_a = na;
    m_b = nb;
  endtask

  task automatic tick();
    model_edge();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [2:0] model_tap_a();
    return {m_a[2], m_a[1], m_a[0]};
  endfunction

  function automatic logic [15:0] model_tap_b();
    return {m_b[1], m_b[0]};
  endfunction

  task automatic add(input string n, input logic r, input logic [2:0] s,
                     input logic d, input logic [2:0] t);
    vec_t v;
    v.name = n; v.rst = r; v.sel = s; v.din = d; v.tap = t;
    tbl.push_back(v);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_a = 1'b1; sel_a = 3'b000; din_a = 1'b1;
    rst_b = 1'b1; sel_b = 2'b00;  din_b = 8'h00;
    for (int k = 0; k < 3; k++) m_a[k] = 1'b0;
    for (int k = 0; k < 2; k++) m_b[k] = 8'h00;

    add("reset",        1'b1, 3'b000, 1'b1, 3'b000);
    add("shift_e1",     1'b0, 3'b000, 1'b1, 3'b001);
    add("shift_e2",     1'b0, 3'b000, 1'b0, 3'b010);
    add("shift_e3",     1'b0, 3'b000, 1'b1, 3'b101);
    add("shift_e4",     1'b0, 3'b000, 1'b1, 3'b011);
    add("shift_e5",     1'b0, 3'b000, 1'b0, 3'b110);
    add("shift_e6",     1'b0, 3'b000, 1'b0, 3'b100);
    add("reload_rst",   1'b1, 3'b000, 1'b0, 3'b000);
    add("load_1",       1'b0, 3'b000, 1'b1, 3'b001);
    add("load_0",       1'b0, 3'b000, 1'b0, 3'b010);
    add("load_101",     1'b0, 3'b000, 1'b1, 3'b101);
    add("hold_1",       1'b0, 3'b111, 1'b0, 3'b101);
    add("hold_2",       1'b0, 3'b111, 1'b1, 3'b101);
    add("hold_3",       1'b0, 3'b111, 1'b0, 3'b101);
    add("hold_4",       1'b0, 3'b111, 1'b1, 3'b101);
    add("hold_5",       1'b0, 3'b111, 1'b0, 3'b101);
    add("mixed_pre",    1'b0, 3'b000, 1'b1, 3'b011);
    add("mixed_sel010", 1'b0, 3'b010, 1'b0, 3'b110);
    add("rst_over_sel", 1'b1, 3'b111, 1'b1, 3'b000);
    add("refill_1",     1'b0, 3'b000, 1'b1, 3'b001);
    add("refill_2",     1'b0, 3'b000, 1'b1, 3'b011);
    add("mid_reset",    1'b1, 3'b000, 1'b1, 3'b000);
    add("post_release", 1'b0, 3'b000, 1'b1, 3'b001);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst;
      sel_a = tbl[i].sel;
      din_a = tbl[i].din;
      tick();
      chk({tbl[i].name, "_tap"},  {13'd0, tap_a}, {13'd0, tbl[i].tap});
      chk({tbl[i].name, "_dout"}, {15'd0, dout_a}, {15'd0, tbl[i].tap[2]});
    end

    // Width case on the 2x8 line: two-edge latency per byte.
    rst_b = 1'b1; sel_b = 2'b00; din_b = 8'hFF;
    tick();
    chk("w_reset", tap_b, 16'h0000);
    rst_b = 1'b0; din_b = 8'hA5;
    tick();
    chk("w_e1", tap_b, 16'h00A5);
    din_b = 8'h3C;
    tick();
    chk("w_e2_dout", {8'd0, dout_b}, 16'h00A5);
    din_b = 8'h00;
    tick();
    chk("w_e3_dout", {8'd0, dout_b}, 16'h003C);

    // Random traffic on both lines against the model.
    for (int n = 0; n < 400; n++) begin
      rst_a = ($urandom_range(0, 15) == 0);
      rst_b = ($urandom_range(0, 15) == 0);
      sel_a = 3'($urandom_range(0, 7));
      sel_b = 2'($urandom_range(0, 3));
      din_a = 1'($urandom_range(0, 1));
      din_b = 8'($urandom_range(0, 255));
      tick();
      chk("rnd_tap_a", {13'd0, tap_a}, {13'd0, model_tap_a()});
      chk("rnd_dout_a", {15'd0, dout_a}, {15'd0, m_a[2]});
      chk("rnd_tap_b", tap_b, model_tap_b());
      chk("rnd_dout_b", {8'd0, dout_b}, {8'd0, m_b[1]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
